dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller.
- Sits between the single-cycle core's load/store port and main memory.
- Responds to the core's Memread/Memwrite strobes (lw/sw) and stalls the core on misses and writes.
- Initiates read/write transactions to main memory over a req/ready handshake.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, word width; one word per line.
- IDX_W, 4, index bits; 2**IDX_W lines.
- CNT_W, 16, width of hit/miss counters (wrap-around).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cpu_addr  in  ADDR_W  load/store byte address (word aligned; bits [1:0] ignored)
- cpu_wdata  in  DATA_W  store data
- cpu_memread  in  1  load request
- cpu_memwrite  in  1  store request
- cpu_rdata  out  DATA_W  load data
- cpu_stall  out  1  core must hold PC and request while high
- mem_addr  out  ADDR_W  memory address (word aligned)
- mem_wdata  out  DATA_W  memory write data
- mem_read  out  1  memory read request, held until mem_ready
- mem_write  out  1  memory write request, held until mem_ready
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle completion pulse
- hit_count  out  CNT_W  load hits
- miss_count  out  CNT_W  load misses

Behaviour:
- Address split: index = cpu_addr[IDX_W+1:2], tag = cpu_addr[ADDR_W-1:IDX_W+2].
- Per line: valid bit, tag, data.
- Reset (async):
  - All valid bits = 0; state = IDLE.
  - mem_read = mem_write = 0; mem_addr = mem_wdata = 0; counters = 0.
  - cpu_stall = 0, cpu_rdata = 0 until the first request.
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE, no request:
  - cpu_stall = 0.
  - mem_ready is ignored.
- IDLE, cpu_memread, hit (valid & tag match):
  - cpu_rdata = line data combinationally, cpu_stall = 0.
  - hit_count += 1 at the clock edge.
- IDLE, cpu_memread, miss:
  - cpu_stall = 1 combinationally.
  - At the edge: latch word address into mem_addr, set mem_read = 1, miss_count += 1, go to RD_WAIT.
- IDLE, cpu_memwrite:
  - cpu_stall = 1.
  - At the edge: latch mem_addr/mem_wdata, set mem_write = 1, go to WR_WAIT.
  - On a hit, the line data is updated at this same edge.
  - On a miss, the line is untouched (no allocate).
- Simultaneous cpu_memread and cpu_memwrite: treated as a write; the read is dropped.
- RD_WAIT:
  - mem_read is held with a stable address.
  - cpu_stall = ~mem_ready, and cpu_rdata = mem_rdata when mem_ready is high.
  - On mem_ready: line filled (valid = 1, tag, data), mem_read = 0, go to IDLE.
  - The core advances on this same edge.
- WR_WAIT:
  - mem_write is held.
  - cpu_stall = ~mem_ready.
  - On mem_ready: mem_write = 0, go to IDLE.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss or any write: 1 + L stall cycles, where L is the number of cycles from request assertion to mem_ready.
  - Zero-wait memory (mem_ready in the first cycle of mem_read): exactly 1 stall cycle.
- Core inputs are ignored outside IDLE; the controller uses its latched copies.
- Counters wrap modulo 2**CNT_W.
- Reset mid-transaction: request dropped immediately, all lines invalidated, state = IDLE. A mem_ready arriving later is ignored.

Decomposition:
- Shared package cache_pkg:
  - state encoding (IDLE = 0, RD_WAIT = 1, WR_WAIT = 2);
  - derived widths TAG_W = ADDR_W - IDX_W - 2 and LINES = 2**IDX_W.
- Sub-module dcache_array:
  - valid/tag/data storage;
  - asynchronous read, synchronous write;
  - async clear of valid bits on rst.
- The FSM and counters stay in dcache_ctrl.

Test Plan:
- Cold read: reset, lw 0x0000_0040, memory returns 0xDEADBEEF with mem_ready 3 cycles after mem_read -> cpu_stall high 4 cycles; mem_addr = 0x40; cpu_rdata = 0xDEADBEEF on the release cycle; miss_count = 1.
- Re-read the same address -> cpu_stall = 0, cpu_rdata = 0xDEADBEEF same cycle, no mem_read, hit_count = 1.
- Conflict miss: read 0x40 then 0x440 (same index, different tag) -> second access misses. A following read of 0x40 misses again; miss_count = 3.
- Write hit/miss:
  - sw 0x12345678 to 0x40 (cached) -> mem_write with mem_addr = 0x40; a later lw of 0x40 hits with 0x12345678.
  - sw to uncached 0x80 -> mem_write issued; a later lw of 0x80 misses.
- Zero-wait memory and simultaneous request:
  - mem_ready in the same cycle as mem_read -> exactly 1 stall cycle.
  - cpu_memread and cpu_memwrite both high -> only mem_write is issued.
- Reset in RD_WAIT -> mem_read drops asynchronously, state = IDLE; a stray mem_ready afterwards is ignored; the previously cached address now misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// default geometry, derived widths and controller state encoding.
package cache_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_IDX_W  = 4;
    localparam int DEF_CNT_W  = 16;

    localparam int TAG_W = DEF_ADDR_W - DEF_IDX_W - 2;
    localparam int LINES = 2 ** DEF_IDX_W;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_WR_WAIT = 2'd2;

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: valid/tag/data per line, asynchronous read,
// synchronous write, valid bits cleared asynchronously on reset.
module dcache_array
    import cache_pkg::*;
#(
    parameter int IDX_W      = DEF_IDX_W,
    parameter int LINE_TAG_W = TAG_W,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic [LINE_TAG_W-1:0] rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [LINE_TAG_W-1:0] wr_tag,
    input  logic [DATA_W-1:0]     wr_data
);

    localparam int LINES_N = 2 ** IDX_W;

    logic [LINES_N-1:0]    valid_q, valid_d;
    logic [LINE_TAG_W-1:0] tag_mem  [LINES_N];
    logic [DATA_W-1:0]     data_mem [LINES_N];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data need no reset: a line is only looked at once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller that
// stalls the core on load misses and on every store.
module dcache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_memread,
    input  logic              cpu_memwrite,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int LINE_TAG_W = ADDR_W - IDX_W - 2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [CNT_W-1:0]      hit_q, hit_d;
    logic [CNT_W-1:0]      miss_q, miss_d;

    logic [ADDR_W-1:0]     req_addr;
    logic [IDX_W-1:0]      req_idx;
    logic [LINE_TAG_W-1:0] req_tag;
    logic                  line_valid;
    logic [LINE_TAG_W-1:0] line_tag;
    logic [DATA_W-1:0]     line_data;
    logic                  line_hit;

    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [LINE_TAG_W-1:0] wr_tag;
    logic [DATA_W-1:0]     wr_data;

    logic                  unused_byte_offset;

    assign req_addr           = {cpu_addr[ADDR_W-1:2], 2'b00};
    assign req_idx            = cpu_addr[IDX_W+1:2];
    assign req_tag            = cpu_addr[ADDR_W-1:IDX_W+2];
    assign line_hit           = line_valid && (line_tag == req_tag);
    assign unused_byte_offset = ^cpu_addr[1:0];

    dcache_array #(
        .IDX_W      (IDX_W),
        .LINE_TAG_W (LINE_TAG_W),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        cpu_stall   = 1'b0;
        cpu_rdata   = '0;
        wr_en       = 1'b0;
        wr_idx      = req_idx;
        wr_tag      = req_tag;
        wr_data     = cpu_wdata;

        case (state_q)
            ST_IDLE: begin
                // A store wins over a simultaneous load; the load is dropped.
                if (cpu_memwrite) begin
                    cpu_stall   = 1'b1;
                    mem_addr_d  = req_addr;
                    mem_wdata_d = cpu_wdata;
                    mem_write_d = 1'b1;
                    wr_en       = line_hit;
                    state_d     = ST_WR_WAIT;
                end else if (cpu_memread) begin
                    if (line_hit) begin
                        cpu_rdata = line_data;
                        hit_d     = hit_q + 1'b1;
                    end else begin
                        cpu_stall  = 1'b1;
                        mem_addr_d = req_addr;
                        mem_read_d = 1'b1;
                        miss_d     = miss_q + 1'b1;
                        state_d    = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                cpu_stall = ~mem_ready;
                if (mem_ready) begin
                    cpu_rdata  = mem_rdata;
                    wr_en      = 1'b1;
                    wr_idx     = mem_addr_q[IDX_W+1:2];
                    wr_tag     = mem_addr_q[ADDR_W-1:IDX_W+2];
                    wr_data    = mem_rdata;
                    mem_read_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_WR_WAIT: begin
                cpu_stall = ~mem_ready;
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random load/store
// traffic against a word-level memory model and a line-presence cache model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_memread;
    logic        cpu_memwrite;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    dcache_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_memread  (cpu_memread),
        .cpu_memwrite (cpu_memwrite),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] ref_mem   [1024];
    logic [31:0] mem_store [1024];
    bit          ref_valid [16];
    logic [31:0] ref_addr  [16];
    int          ref_hits = 0;
    int          ref_misses = 0;
    txn_t        txn_q[$];
    logic [31:0] rd_q[$];
    int          next_lat = 0;
    bit          stray_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One core access: predicts the outcome, drives it, holds it while stalled.
    task automatic op(input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wd, input int lat, input string name);
        logic [31:0] wa = {addr[31:2], 2'b00};
        int          idx = int'(addr[5:2]);
        int          w = int'(addr[11:2]);
        int          exp_stall = 0;
        int          stalls = 0;
        bit          done = 1'b0;
        txn_t        t;
        if (wr) begin
            t.wr = 1'b1; t.addr = wa; t.data = wd;
            txn_q.push_back(t);
            exp_stall = 1 + lat;
            ref_mem[w] = wd;
        end else if (rd) begin
            if (ref_valid[idx] && ref_addr[idx] == wa) begin
                ref_hits++;
            end else begin
                exp_stall = 1 + lat;
                ref_misses++;
                t.wr = 1'b0; t.addr = wa; t.data = '0;
                txn_q.push_back(t);
                ref_valid[idx] = 1'b1;
                ref_addr[idx] = wa;
            end
            rd_q.push_back(ref_mem[w]);
        end
        next_lat     = lat;
        cpu_addr     = addr;
        cpu_wdata    = wd;
        cpu_memread  = rd;
        cpu_memwrite = wr;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall) done = 1'b1;
            else stalls++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: cpu_stall still 1 after 20 cycles, required release", name);
        end
        check({name, " stall cycles"}, 32'(stalls), 32'(exp_stall));
        @(posedge clk);
        #1;
        cpu_memread  = 1'b0;
        cpu_memwrite = 1'b0;
    endtask

    // Load-data monitor: one completion per negedge where a pure load is not stalled.
    always @(negedge clk) begin
        if (!rst && cpu_memread && !cpu_memwrite && !cpu_stall) begin
            if (rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL load completion: got data 0x%08h, expected no load pending", cpu_rdata);
            end else begin
                check("load data", cpu_rdata, rd_q.pop_front());
            end
        end
    end

    // Memory responder; checks each new request against the expected transaction queue.
    initial begin
        txn_t t;
        bit   busy = 1'b0;
        int   wait_cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else if (stray_req) begin
                mem_ready = 1'b1;
            end else if (mem_read || mem_write) begin
                if (!busy) begin
                    busy = 1'b1;
                    wait_cnt = next_lat;
                    if (txn_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL mem request: got rd=%0b wr=%0b addr 0x%08h, expected none",
                                 mem_read, mem_write, mem_addr);
                    end else begin
                        t = txn_q.pop_front();
                        check("mem_read", {31'b0, mem_read}, {31'b0, !t.wr});
                        check("mem_write", {31'b0, mem_write}, {31'b0, t.wr});
                        check("mem_addr", mem_addr, t.addr);
                        if (t.wr) check("mem_wdata", mem_wdata, t.data);
                    end
                end
                if (wait_cnt == 0) begin
                    mem_ready = 1'b1;
                    busy = 1'b0;
                    if (mem_write) mem_store[mem_addr[11:2]] = mem_wdata;
                    else mem_rdata = mem_store[mem_addr[11:2]];
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    initial begin
        logic [31:0] v;
        int          kind;
        rst = 1'b1;
        cpu_addr = '0;
        cpu_wdata = '0;
        cpu_memread = 1'b0;
        cpu_memwrite = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            v = (32'(i) * 32'h9E37_79B1) ^ 32'h1234_5678;
            ref_mem[i] = v;
            mem_store[i] = v;
        end
        ref_mem[16] = 32'hDEAD_BEEF;
        mem_store[16] = 32'hDEAD_BEEF;
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset cpu_stall", {31'b0, cpu_stall}, 32'd0);
        check("reset cpu_rdata", cpu_rdata, 32'd0);
        check("reset mem_read", {31'b0, mem_read}, 32'd0);
        check("reset mem_write", {31'b0, mem_write}, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset mem_wdata", mem_wdata, 32'd0);
        check("reset hit_count", {16'h0, hit_count}, 32'd0);
        check("reset miss_count", {16'h0, miss_count}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        op(1'b1, 1'b0, 32'h40, 32'h0, 3, "cold read");
        check("cold mem_addr", mem_addr, 32'h40);
        check("cold miss_count", {16'h0, miss_count}, 32'd1);
        op(1'b1, 1'b0, 32'h40, 32'h0, 3, "re-read hit");
        check("re-read hit_count", {16'h0, hit_count}, 32'd1);
        op(1'b1, 1'b0, 32'h440, 32'h0, 1, "conflict read");
        op(1'b1, 1'b0, 32'h40, 32'h0, 2, "conflict re-read");
        check("conflict miss_count", {16'h0, miss_count}, 32'd3);
        op(1'b0, 1'b1, 32'h40, 32'h1234_5678, 1, "write hit");
        op(1'b1, 1'b0, 32'h40, 32'h0, 0, "read after write hit");
        op(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 0, "write miss");
        op(1'b1, 1'b0, 32'h80, 32'h0, 0, "read after write miss");
        op(1'b1, 1'b1, 32'h100, 32'hA5A5_5A5A, 0, "read+write");
        op(1'b1, 1'b0, 32'h100, 32'h0, 2, "read after read+write");

        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 9));
            op(kind < 6 || kind == 9, kind >= 6, 32'($urandom_range(0, 255)) << 2, $urandom,
               int'($urandom_range(0, 3)), "random op");
        end
        check("random hit_count", {16'h0, hit_count}, 32'(ref_hits & 32'hFFFF));
        check("random miss_count", {16'h0, miss_count}, 32'(ref_misses & 32'hFFFF));

        // Reset while a read miss is outstanding.
        op(1'b1, 1'b0, 32'h40, 32'h0, 1, "pre-reset read");
        begin
            txn_t t;
            t.wr = 1'b0; t.addr = 32'h840; t.data = '0;
            txn_q.push_back(t);
        end
        next_lat = 3;
        cpu_addr = 32'h840;
        cpu_memread = 1'b1;
        @(posedge clk);
        #1;
        check("rd_wait mem_read", {31'b0, mem_read}, 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        cpu_memread = 1'b0;
        #1;
        check("mid-reset mem_read", {31'b0, mem_read}, 32'd0);
        check("mid-reset cpu_stall", {31'b0, cpu_stall}, 32'd0);
        check("mid-reset mem_addr", mem_addr, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
        ref_hits = 0;
        ref_misses = 0;
        stray_req = 1'b1;
        @(posedge clk);
        #2;
        stray_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("stray mem_read", {31'b0, mem_read}, 32'd0);
        check("stray mem_write", {31'b0, mem_write}, 32'd0);
        check("stray miss_count", {16'h0, miss_count}, 32'd0);
        check("stray hit_count", {16'h0, hit_count}, 32'd0);
        op(1'b1, 1'b0, 32'h40, 32'h0, 2, "post-reset read");
        check("post-reset miss_count", {16'h0, miss_count}, 32'd1);

        repeat (2) @(posedge clk);
        check("load queue drained", 32'(rd_q.size()), 32'd0);
        check("mem queue drained", 32'(txn_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
